// File: rtl/rv32i_io_pkg.sv
// Shared register map definitions for the rv32i GPIO window.
// Word offsets and the decoded register select used by io_addr[3:2].
package rv32i_io_pkg;

   localparam logic [3:0] GPIO_LED_OFS   = 4'h0;
   localparam logic [3:0] GPIO_KEYST_OFS = 4'h4;
   localparam logic [3:0] GPIO_EDGE_OFS  = 4'h8;
   localparam logic [3:0] GPIO_IRQEN_OFS = 4'hC;

   typedef enum logic [1:0] {
      SEL_LED   = GPIO_LED_OFS[3:2],
      SEL_KEYST = GPIO_KEYST_OFS[3:2],
      SEL_EDGE  = GPIO_EDGE_OFS[3:2],
      SEL_IRQEN = GPIO_IRQEN_OFS[3:2]
   } reg_sel_e;

   function automatic reg_sel_e addr_sel(input logic [3:0] ofs);
      return reg_sel_e'(ofs[3:2]);
   endfunction

endpackage

// File: rtl/rv32i_key_debounce.sv
// One key: 2-flop synchroniser, polarity normalise, debounce counter.
// press_o pulses on the same edge the stable state goes 0->1.
module rv32i_key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic state_o,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic REL = (KEY_ACTIVE_LOW != 0);

   logic          sync1_q;
   logic          sync2_q;
   logic          level;
   logic          stable_q;
   logic          stable_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          hit;

   assign level = sync2_q ^ REL;
   assign hit   = (level != stable_q) && (cnt_q == TERM);

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (level == stable_q) begin
         cnt_d = '0;
      end else if (hit) begin
         stable_d = level;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= REL;
         sync2_q  <= REL;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= key_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign state_o = stable_q;
   assign press_o = hit & level;

endmodule

// File: rtl/rv32i_gpio_ctrl.sv
// Memory-mapped GPIO: LED bank, debounced keys, W1C press flags, IRQ.
// Bus decode, registers and the interrupt flop live here.
module rv32i_gpio_ctrl
   import rv32i_io_pkg::*;
#(
   parameter int ADDR_WIDTH      = 15,
   parameter int NUM_KEYS        = 2,
   parameter int NUM_LEDS        = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_KEYS-1:0]   KEY,
   input  logic                  io_we,
   input  logic [ADDR_WIDTH-1:0] io_addr,
   input  logic [31:0]           io_wdata,
   output logic [NUM_LEDS-1:0]   LEDR,
   output logic [31:0]           io_rdata,
   output logic                  irq
);

   reg_sel_e sel;

   logic [NUM_KEYS-1:0] key_state;
   logic [NUM_KEYS-1:0] press;

   logic [NUM_LEDS-1:0] led_q;
   logic [NUM_LEDS-1:0] led_d;
   logic [NUM_KEYS-1:0] edge_q;
   logic [NUM_KEYS-1:0] edge_d;
   logic [NUM_KEYS-1:0] irqen_q;
   logic [NUM_KEYS-1:0] irqen_d;
   logic [31:0]         rdata_q;
   logic [31:0]         rdata_d;
   logic                irq_q;
   logic                irq_d;

   logic [31:0] led_rd;
   logic [31:0] keyst_rd;
   logic [31:0] edge_rd;
   logic [31:0] irqen_rd;

   logic unused_ok;

   assign sel       = addr_sel(io_addr[3:0]);
   assign unused_ok = ^{io_addr, io_wdata};

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      rv32i_key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_deb (
         .clk_i   (clk),
         .rst_ni  (reset),
         .key_i   (KEY[i]),
         .state_o (key_state[i]),
         .press_o (press[i])
      );
   end

   always_comb begin
      led_rd   = '0;
      keyst_rd = '0;
      edge_rd  = '0;
      irqen_rd = '0;
      led_rd[NUM_LEDS-1:0]   = led_q;
      keyst_rd[NUM_KEYS-1:0] = key_state;
      edge_rd[NUM_KEYS-1:0]  = edge_q;
      irqen_rd[NUM_KEYS-1:0] = irqen_q;
   end

   // A press landing on the same edge as its W1C clear wins.
   always_comb begin
      led_d   = led_q;
      edge_d  = edge_q | press;
      irqen_d = irqen_q;
      rdata_d = rdata_q;
      irq_d   = |(edge_q & irqen_q);
      if (io_we) begin
         unique case (sel)
            SEL_LED:   led_d   = io_wdata[NUM_LEDS-1:0];
            SEL_KEYST: ;
            SEL_EDGE:  edge_d  = (edge_q & ~io_wdata[NUM_KEYS-1:0]) | press;
            SEL_IRQEN: irqen_d = io_wdata[NUM_KEYS-1:0];
         endcase
      end else begin
         unique case (sel)
            SEL_LED:   rdata_d = led_rd;
            SEL_KEYST: rdata_d = keyst_rd;
            SEL_EDGE:  rdata_d = edge_rd;
            SEL_IRQEN: rdata_d = irqen_rd;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_q   <= '0;
         edge_q  <= '0;
         irqen_q <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         led_q   <= led_d;
         edge_q  <= edge_d;
         irqen_q <= irqen_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign LEDR     = led_q;
   assign io_rdata = rdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_rv32i_gpio_ctrl.sv
// Bench for rv32i_gpio_ctrl: directed register/debounce cases plus
// randomized keys and bus traffic against a window-based key model.
module tb_rv32i_gpio_ctrl;

   localparam int AW = 15;
   localparam int NK = 2;
   localparam int NL = 10;
   localparam int D  = 8;
   localparam int AL = 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NK-1:0] KEY = '1;
   logic          io_we = 1'b0;
   logic [AW-1:0] io_addr = '0;
   logic [31:0]   io_wdata = '0;
   logic [NL-1:0] LEDR;
   logic [31:0]   io_rdata;
   logic          irq;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   rv32i_gpio_ctrl #(
      .ADDR_WIDTH      (AW),
      .NUM_KEYS        (NK),
      .NUM_LEDS        (NL),
      .DEBOUNCE_CYCLES (D),
      .KEY_ACTIVE_LOW  (AL)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .KEY      (KEY),
      .io_we    (io_we),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .LEDR     (LEDR),
      .io_rdata (io_rdata),
      .irq      (irq)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: a key flips once its synchronised level has
   // disagreed with the stable level over a full window of D edges.
   logic [NK-1:0] p1_m, p2_m, stab_m, edge_m, en_m;
   logic [NK-1:0] p1_n, p2_n, stab_n, edge_n, en_n, press_n;
   logic [NL-1:0] led_m, led_n;
   logic [31:0]   rdata_m, rdata_n, view;
   logic          irq_m, irq_n;
   logic [D-1:0]  hist_m [NK];
   logic [D-1:0]  hist_n [NK];
   int            since_m [NK];
   int            since_n [NK];

   always_comb begin
      p1_n    = KEY;
      p2_n    = p1_m;
      stab_n  = stab_m;
      press_n = '0;
      hist_n  = hist_m;
      since_n = since_m;
      for (int k = 0; k < NK; k++) begin
         hist_n[k]  = {hist_m[k][D-2:0], p2_m[k] ^ 1'(AL)};
         since_n[k] = (since_m[k] >= D) ? D : since_m[k] + 1;
         if (since_n[k] >= D && hist_n[k] == {D{~stab_m[k]}}) begin
            stab_n[k]  = ~stab_m[k];
            press_n[k] = ~stab_m[k];
            since_n[k] = 0;
         end
      end
      led_n  = led_m;
      en_n   = en_m;
      edge_n = edge_m | press_n;
      irq_n  = |(edge_m & en_m);
      case (io_addr[3:2])
         2'd0:    view = {22'b0, led_m};
         2'd1:    view = {30'b0, stab_m};
         2'd2:    view = {30'b0, edge_m};
         default: view = {30'b0, en_m};
      endcase
      rdata_n = io_we ? rdata_m : view;
      if (io_we) begin
         case (io_addr[3:2])
            2'd0:    led_n  = io_wdata[NL-1:0];
            2'd2:    edge_n = (edge_m & ~io_wdata[NK-1:0]) | press_n;
            2'd3:    en_n   = io_wdata[NK-1:0];
            default: ;
         endcase
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_m    <= '1;
         p2_m    <= '1;
         stab_m  <= '0;
         edge_m  <= '0;
         en_m    <= '0;
         led_m   <= '0;
         rdata_m <= '0;
         irq_m   <= 1'b0;
         hist_m  <= '{default: '0};
         since_m <= '{default: 0};
      end else begin
         p1_m    <= p1_n;
         p2_m    <= p2_n;
         stab_m  <= stab_n;
         edge_m  <= edge_n;
         en_m    <= en_n;
         led_m   <= led_n;
         rdata_m <= rdata_n;
         irq_m   <= irq_n;
         hist_m  <= hist_n;
         since_m <= since_n;
      end
   end

   always @(posedge clk) begin
      #1;
      if (reset && chk_en) begin
         check("model LEDR", 32'(LEDR), 32'(led_m));
         check("model rdata", io_rdata, rdata_m);
         check("model irq", 32'(irq), 32'(irq_m));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      io_we = 1'b1;
      io_addr = a;
      io_wdata = d;
      @(negedge clk);
      io_we = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp,
                     input string nm);
      @(negedge clk);
      io_we = 1'b0;
      io_addr = a;
      @(negedge clk);
      check(nm, io_rdata, exp);
   endtask

   task automatic rand_phase(input int n);
      repeat (n) begin
         @(negedge clk);
         for (int k = 0; k < NK; k++)
            if ($urandom_range(0, 13) == 0) KEY[k] = ~KEY[k];
         io_we = ($urandom_range(0, 3) == 0);
         io_addr = AW'($urandom);
         io_wdata = $urandom;
      end
      @(negedge clk);
      io_we = 1'b0;
   endtask

   initial begin : stim
      logic saw;
      tick(3);
      reset = 1'b1;
      chk_en = 1'b1;
      rand_phase(200);

      @(negedge clk);
      reset = 1'b0;
      KEY = '1;
      io_we = 1'b0;
      tick(2);
      reset = 1'b1;
      check("reset LEDR", 32'(LEDR), 32'h0);
      check("reset irq", 32'(irq), 32'h0);
      rd(15'h0000, 32'h0, "reset LED");
      rd(15'h0004, 32'h0, "reset KEYST");
      rd(15'h0008, 32'h0, "reset EDGE");
      rd(15'h000C, 32'h0, "reset IRQEN");

      wr(15'h0000, 32'hFFFF_F2A5);
      check("LEDR after write", 32'(LEDR), 32'h2A5);
      check("model LED pin", 32'(led_m), 32'h2A5);
      rd(15'h1233, 32'h0000_02A5, "LED readback");
      wr(15'h0004, 32'hFFFF_FFFF);
      rd(15'h0004, 32'h0, "KEYST write ignored");
      wr(15'h000C, 32'h1);

      @(negedge clk);
      io_addr = 15'h0004;
      saw = 1'b0;
      repeat (2) begin
         KEY[0] = 1'b0;
         repeat (3) begin @(negedge clk); saw |= io_rdata[0]; end
         KEY[0] = 1'b1;
         repeat (3) begin @(negedge clk); saw |= io_rdata[0]; end
      end
      KEY[0] = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k < 10) saw |= io_rdata[0];
         if (k == 10) check("debounce early", io_rdata, 32'h0);
         if (k == 11) check("debounce state", io_rdata, 32'h1);
      end
      check("bounce never set", 32'(saw), 32'h0);
      check("model stable pin", 32'(stab_m), 32'h1);
      check("irq on press", 32'(irq), 32'h1);

      rd(15'h0008, 32'h1, "edge after press");
      wr(15'h0008, 32'h0);
      rd(15'h0008, 32'h1, "W1C zero keeps");
      wr(15'h0008, 32'h1);
      tick(1);
      check("irq after clear", 32'(irq), 32'h0);
      rd(15'h0008, 32'h0, "edge cleared");

      KEY[0] = 1'b1;
      tick(14);
      @(negedge clk);
      KEY[0] = 1'b0;
      repeat (9) @(negedge clk);
      io_we = 1'b1;
      io_addr = 15'h0008;
      io_wdata = 32'h1;
      @(negedge clk);
      io_we = 1'b0;
      check("model collision", 32'(edge_m), 32'h1);
      tick(1);
      check("irq collision", 32'(irq), 32'h1);
      rd(15'h0008, 32'h1, "collision edge");

      wr(15'h000C, 32'h0);
      wr(15'h0008, 32'h3);
      KEY[1] = 1'b0;
      tick(14);
      rd(15'h0008, 32'h2, "masked edge");
      check("masked irq", 32'(irq), 32'h0);
      wr(15'h000C, 32'h2);
      tick(1);
      check("enable flagged irq", 32'(irq), 32'h1);
      wr(15'h0008, 32'h3);
      KEY[1] = 1'b1;
      tick(14);
      rd(15'h0008, 32'h0, "release no flag");
      rd(15'h0004, 32'h1, "key state after release");
      check("irq after release", 32'(irq), 32'h0);

      rand_phase(3000);
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
